// File: rtl/gnrl_pkg.sv
// Shared sizing helpers for the generic queue family.
// Pointer and count widths are derived here so every queue sizes them alike.
package gnrl_pkg;

  function automatic int unsigned gnrl_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

  // A single-entry queue still carries a 1-bit pointer.
  function automatic int unsigned gnrl_ptr_w(input int unsigned depth);
    return (depth > 1) ? gnrl_clog2(depth) : 1;
  endfunction

  function automatic int unsigned gnrl_cnt_w(input int unsigned depth);
    return gnrl_clog2(depth + 1);
  endfunction

endpackage

// File: rtl/gnrl_fifo_ptr.sv
// Wrapping queue pointer: counts 0..DP-1 on inc_i.
// Synchronous active-high reset returns it to slot 0.
module gnrl_fifo_ptr
  import gnrl_pkg::*;
#(
  parameter int unsigned DP = 4,
  localparam int unsigned PW = gnrl_ptr_w(DP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  localparam logic [PW-1:0] LAST = PW'(DP - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Explicit wrap so non power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/gnrl_fifo.sv
// Synchronous valid/ready FIFO between adjacent pipeline stages.
// Define GNRL_FIFO_BYPASS_EN for a zero-latency pass-through when empty.
module gnrl_fifo
  import gnrl_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned DP = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  output logic                    i_rdy,
  input  logic [DW-1:0]           i_dat,
  output logic                    o_vld,
  input  logic                    o_rdy,
  output logic [DW-1:0]           o_dat,
  output logic [$clog2(DP+1)-1:0] cnt
);

  localparam int unsigned PW = gnrl_ptr_w(DP);
  localparam int unsigned CW = gnrl_cnt_w(DP);
  localparam logic [CW-1:0] FULL = CW'(DP);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [DW-1:0] mem_q [DP];
  logic [DW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          byp;

  assign full  = (cnt_q == FULL);
  assign empty = (cnt_q == '0);
  assign i_rdy = !rst && !full;

`ifdef GNRL_FIFO_BYPASS_EN
  // Empty queue hands the producer word straight to the consumer.
  assign byp   = empty && i_vld && o_rdy;
  assign o_vld = empty ? i_vld : 1'b1;
  assign o_dat = empty ? i_dat : head;
`else
  assign byp   = 1'b0;
  assign o_vld = !empty;
  assign o_dat = head;
`endif

  assign push = i_vld && i_rdy && !byp;
  assign pop  = o_vld && o_rdy && !empty && !rst;

  gnrl_fifo_ptr #(.DP(DP)) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .inc_i(push),
    .ptr_o(wptr)
  );

  gnrl_fifo_ptr #(.DP(DP)) u_rptr (
    .clk  (clk),
    .rst  (rst),
    .inc_i(pop),
    .ptr_o(rptr)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

  // Data storage is load-enabled only; no reset needed.
  for (genvar i = 0; i < DP; i++) begin : g_ent
    always_ff @(posedge clk) begin
      if (push && (wptr == PW'(i))) begin
        mem_q[i] <= i_dat;
      end
    end
  end

  if (DP == 1) begin : g_head1
    logic rptr_unused;
    assign rptr_unused = ^rptr;
    assign head = mem_q[0];
  end else begin : g_headn
    assign head = mem_q[rptr];
  end

endmodule

// File: tb/tb_gnrl_fifo.sv
// Scoreboard bench for gnrl_fifo: DP=4 directed tests and a DP=1 random run.
// Driver queues expected words; a negedge monitor checks every pop.
module tb_gnrl_fifo;

  localparam int DP = 4;
`ifdef GNRL_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_vld;
  logic        i_rdy;
  logic [31:0] i_dat;
  logic        o_vld;
  logic        o_rdy;
  logic [31:0] o_dat;
  logic [2:0]  cnt;

  logic       v1;
  logic       rdy1;
  logic [7:0] d1;
  logic       vld1;
  logic       r1;
  logic [7:0] od1;
  logic [0:0] cnt1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int m_cnt = 0;

  gnrl_fifo #(.DW(32), .DP(DP)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .i_vld(i_vld),
    .i_rdy(i_rdy),
    .i_dat(i_dat),
    .o_vld(o_vld),
    .o_rdy(o_rdy),
    .o_dat(o_dat),
    .cnt  (cnt)
  );

  gnrl_fifo #(.DW(8), .DP(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .i_vld(v1),
    .i_rdy(rdy1),
    .i_dat(d1),
    .o_vld(vld1),
    .o_rdy(r1),
    .o_dat(od1),
    .cnt  (cnt1)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Monitor: every accepted output word must match the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && o_vld === 1'b1 && o_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %0h expected none", o_dat);
      end else begin
        chk("o_dat", o_dat, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input bit rs, input bit v, input logic [31:0] d,
                     input bit r);
    bit e_rdy;
    bit e_vld;
    bit byp;
    rst   = rs;
    i_vld = v;
    i_dat = d;
    o_rdy = r;
    e_rdy = !rs && (m_cnt != DP);
    e_vld = (m_cnt != 0) || (BYP && v);
    byp   = BYP && (m_cnt == 0) && v && r;
    if (v && e_rdy) exp_q.push_back(d);
    @(negedge clk);
    chk("cnt", 32'(cnt), m_cnt);
    chk("i_rdy", 32'(i_rdy), 32'(e_rdy));
    chk("o_vld", 32'(o_vld), 32'(e_vld));
    if (rs) begin
      m_cnt = 0;
      exp_q.delete();
    end else begin
      m_cnt = m_cnt + ((v && e_rdy && !byp) ? 1 : 0)
                    - ((e_vld && r && !byp) ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int m1;
    logic [7:0] q1[$];
    bit e_rdy1;
    bit e_vld1;
    bit byp1;
    rst = 1'b1;
    i_vld = 1'b0;
    o_rdy = 1'b0;
    i_dat = '0;
    v1 = 1'b0;
    r1 = 1'b0;
    d1 = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0);

    // Fill to full, refuse extra word, drain in order.
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'hA0 + i, 0);
    cyc(0, 1, 32'hEE, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

    // Full with push and pop: pop only, word accepted next cycle.
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'hF0 + i, 0);
    cyc(0, 1, 32'h10, 1);
    cyc(0, 1, 32'h10, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Sustained stream at cnt=2, pointers wrap.
    cyc(0, 1, 32'hC0, 0);
    cyc(0, 1, 32'hC1, 0);
    for (int i = 2; i < 12; i++) cyc(0, 1, 32'hC0 + i, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    // Reset mid-operation discards contents.
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hD0 + i, 0);
    cyc(1, 1, 32'hD3, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Empty FIFO offered a word with consumer ready.
    cyc(0, 1, 32'h55, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Single-entry FIFO under random traffic.
    m1 = 0;
    for (int k = 0; k < 1000; k++) begin
      v1 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      d1 = 8'($urandom);
      e_rdy1 = (m1 == 0);
      e_vld1 = (m1 == 1) || (BYP && v1);
      byp1 = BYP && (m1 == 0) && v1 && r1;
      if (v1 && e_rdy1) q1.push_back(d1);
      @(negedge clk);
      chk("dp1_cnt", 32'(cnt1), m1);
      chk("dp1_i_rdy", 32'(rdy1), 32'(e_rdy1));
      chk("dp1_o_vld", 32'(vld1), 32'(e_vld1));
      if (e_vld1 && r1 && q1.size() > 0) begin
        chk("dp1_o_dat", 32'(od1), 32'(q1.pop_front()));
      end
      m1 = m1 + ((v1 && e_rdy1 && !byp1) ? 1 : 0)
              - ((e_vld1 && r1 && !byp1) ? 1 : 0);
      @(posedge clk);
      #1;
    end

    chk("sb_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
